// File: rtl/ppc_pkg.sv
// Shared constants for the ping-pong counter bank: direction encoding and reset defaults.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ppc_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Reset defaults; min/max are width-dependent and expressed as '0 / '1 at the use site
  localparam logic RST_DIR       = DIR_UP;
  localparam logic RST_WRAP      = 1'b0;
  localparam logic RST_BOUNCE    = 1'b0;
  localparam logic RST_CFG_READY = 1'b1;
  localparam int   RST_STEP      = 1;

endpackage

// File: rtl/ppc_channel.sv
// One ping-pong channel: bound/step registers, counter, direction and bounce pulse.
// Latency: one cycle from enable/load sample to registered outputs.
// Backpressure: none; load_i always wins over counting in the same cycle.
module ppc_channel
  import ppc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] cfg_min_i,
  input  logic [WIDTH-1:0] cfg_max_i,
  input  logic [WIDTH-1:0] cfg_step_i,
  input  logic             cfg_wrap_i,
  input  logic             enable_i,
  input  logic             flip_i,
  output logic [WIDTH-1:0] out_o,
  output logic             dir_o,
  output logic             bounce_o
);

  typedef struct packed {
    logic [WIDTH-1:0] min_v;
    logic [WIDTH-1:0] max_v;
    logic [WIDTH-1:0] step_v;
    logic [WIDTH-1:0] out_v;
    logic             dir;
    logic             wrap;
  } chan_state_t;

  chan_state_t      state_q, state_d;
  logic             bounce_q, bounce_d;
  logic [WIDTH:0]   up_sum, dn_diff;
  logic [WIDTH-1:0] up_val, dn_val;
  logic             invalid;
  logic             new_dir;

  // One-step moves in each direction, computed one bit wider and clamped onto the bounds
  always_comb begin
    up_sum  = {1'b0, state_q.out_v} + {1'b0, state_q.step_v};
    dn_diff = {1'b0, state_q.out_v} - {1'b0, state_q.step_v};
    up_val  = (up_sum > {1'b0, state_q.max_v}) ? state_q.max_v : up_sum[WIDTH-1:0];
    dn_val  = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < state_q.min_v)) ? state_q.min_v
                                                                        : dn_diff[WIDTH-1:0];
    invalid = (state_q.out_v > state_q.max_v) || (state_q.out_v < state_q.min_v) ||
              (state_q.min_v == state_q.max_v);
  end

  // Next state: config load, else bound reversal / flip / plain step when valid and enabled
  always_comb begin
    state_d  = state_q;
    bounce_d = 1'b0;
    new_dir  = state_q.dir;
    if (load_i) begin
      state_d.min_v  = cfg_min_i;
      state_d.max_v  = cfg_max_i;
      state_d.step_v = (cfg_step_i == '0) ? WIDTH'(RST_STEP) : cfg_step_i;
      state_d.out_v  = cfg_min_i;
      state_d.dir    = DIR_UP;
      state_d.wrap   = cfg_wrap_i;
    end else if (!invalid && enable_i) begin
      if (state_q.wrap) begin
        state_d.dir = DIR_UP;
        if (state_q.out_v == state_q.max_v) begin
          state_d.out_v = state_q.min_v;
          bounce_d      = 1'b1;
        end else begin
          state_d.out_v = up_val;
        end
      end else if (state_q.out_v == state_q.max_v) begin
        state_d.out_v = dn_val;
        state_d.dir   = DIR_DOWN;
        bounce_d      = 1'b1;
      end else if (state_q.out_v == state_q.min_v) begin
        state_d.out_v = up_val;
        state_d.dir   = DIR_UP;
        bounce_d      = 1'b1;
      end else begin
        new_dir       = state_q.dir ^ flip_i;
        state_d.dir   = new_dir;
        state_d.out_v = (new_dir == DIR_UP) ? up_val : dn_val;
      end
    end
  end

  // Channel registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q.min_v  <= '0;
      state_q.max_v  <= '1;
      state_q.step_v <= WIDTH'(RST_STEP);
      state_q.out_v  <= '0;
      state_q.dir    <= RST_DIR;
      state_q.wrap   <= RST_WRAP;
      bounce_q       <= RST_BOUNCE;
    end else begin
      state_q  <= state_d;
      bounce_q <= bounce_d;
    end
  end

  assign out_o    = state_q.out_v;
  assign dir_o    = state_q.dir;
  assign bounce_o = bounce_q;

endmodule

// File: rtl/ppc_multi_channel.sv
// Bank of CHANNELS ping-pong counters with a shared valid/ready config port (PPC_WRAP_MODE_EN adds wrap mode).
// Latency: count and config updates visible one cycle after the sampling edge.
// Backpressure: cfg_ready_o drops for one cycle after every accept (max one write per 2 cycles).
module ppc_multi_channel
  import ppc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       enable_i,
  input  logic [CHANNELS-1:0]       flip_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [CH_W-1:0]           cfg_ch_i,
  input  logic [WIDTH-1:0]          cfg_min_i,
  input  logic [WIDTH-1:0]          cfg_max_i,
  input  logic [WIDTH-1:0]          cfg_step_i,
`ifdef PPC_WRAP_MODE_EN
  input  logic                      cfg_wrap_i,
`endif
  output logic [CHANNELS*WIDTH-1:0] out_o,
  output logic [CHANNELS-1:0]       direction_o,
  output logic [CHANNELS-1:0]       bounce_o
);

  logic                cfg_ready_q, cfg_ready_d;
  logic                cfg_accept;
  logic [CHANNELS-1:0] cfg_load;
  logic                cfg_wrap;

`ifdef PPC_WRAP_MODE_EN
  assign cfg_wrap = cfg_wrap_i;
`else
  assign cfg_wrap = 1'b0;
`endif

  // Config decode: an accepted write to an index beyond the bank loads nothing
  always_comb begin
    cfg_accept  = cfg_valid_i && cfg_ready_q;
    cfg_ready_d = !cfg_accept;
    for (int c = 0; c < CHANNELS; c++) begin
      cfg_load[c] = cfg_accept && (int'(cfg_ch_i) == c);
    end
  end

  // Ready flag: one idle cycle after each accepted write
  always_ff @(posedge clk) begin
    if (!rst_n) cfg_ready_q <= RST_CFG_READY;
    else        cfg_ready_q <= cfg_ready_d;
  end

  assign cfg_ready_o = cfg_ready_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    ppc_channel #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cfg_load[c]),
      .cfg_min_i  (cfg_min_i),
      .cfg_max_i  (cfg_max_i),
      .cfg_step_i (cfg_step_i),
      .cfg_wrap_i (cfg_wrap),
      .enable_i   (enable_i[c]),
      .flip_i     (flip_i[c]),
      .out_o      (out_o[c*WIDTH +: WIDTH]),
      .dir_o      (direction_o[c]),
      .bounce_o   (bounce_o[c])
    );
  end

endmodule
